// File: rtl/exe_mem_pipe_stage.sv
// EX->MEM pipeline stage: valid/ready handshake, 1-entry skid buffer (registered in_ready)
// and synchronous flush. Define EXEMEM_FWD_EN to add the M-entry forwarding/load-use port.
module exe_mem_pipe_stage #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   // EXE side
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          wrf_exe,
   input  logic          wdc_exe,
   input  logic          wdmem_exe,
   input  logic [DW-1:0] alud_exe,
   input  logic [DW-1:0] rd2_exe,
   input  logic [AW-1:0] wa_exe,
`ifdef EXEMEM_FWD_EN
   input  logic [AW-1:0] fwd_ra,
   output logic          fwd_hit,
   output logic          fwd_load,
   output logic [DW-1:0] fwd_data,
`endif
   // MEM side
   output logic          out_valid,
   input  logic          out_ready,
   output logic          wrf_mem,
   output logic          wdc_mem,
   output logic          wdmem_mem,
   output logic [DW-1:0] alud_mem,
   output logic [DW-1:0] rd2_mem,
   output logic [AW-1:0] wa_mem
);

   typedef struct packed {
      logic          wrf;
      logic          wdc;
      logic          wdmem;
      logic [DW-1:0] alud;
      logic [DW-1:0] rd2;
      logic [AW-1:0] wa;
   } entry_t;

   entry_t in_entry;
   entry_t m_q, m_d;
   entry_t s_q, s_d;
   logic   m_valid_q, m_valid_d;
   logic   s_valid_q, s_valid_d;
   logic   in_ready_q;
   logic   fire_in, fire_out, m_free;

   assign in_entry = '{wrf:   wrf_exe,
                       wdc:   wdc_exe,
                       wdmem: wdmem_exe,
                       alud:  alud_exe,
                       rd2:   rd2_exe,
                       wa:    wa_exe};

   assign in_ready = in_ready_q;
   assign fire_in  = in_valid & in_ready_q;
   assign fire_out = m_valid_q & out_ready;
   assign m_free   = ~m_valid_q | fire_out;

   always_comb begin
      // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
      m_d       = m_q;
      s_d       = s_q;
      m_valid_d = m_valid_q;
      s_valid_d = s_valid_q;

      if (flush) begin
         // Squash both entries; a same-cycle fire_in is simply never captured.
         m_valid_d = 1'b0;
         s_valid_d = 1'b0;
         m_d.wrf   = 1'b0;
         m_d.wdc   = 1'b0;
         m_d.wdmem = 1'b0;
      end else if (m_free) begin
         if (s_valid_q) begin
            // in_ready was low, so nothing can arrive this cycle while S drains.
            m_d       = s_q;
            m_valid_d = 1'b1;
            s_valid_d = 1'b0;
         end else if (fire_in) begin
            m_d       = in_entry;
            m_valid_d = 1'b1;
         end else begin
            // Bubble: drop control bits so no RF or memory write can leak out.
            m_valid_d = 1'b0;
            m_d.wrf   = 1'b0;
            m_d.wdc   = 1'b0;
            m_d.wdmem = 1'b0;
         end
      end else if (fire_in) begin
         s_d       = in_entry;
         s_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
      if (rst) begin
         m_q        <= '0;
         m_valid_q  <= 1'b0;
         s_valid_q  <= 1'b0;
         in_ready_q <= 1'b0;
      end else begin
         m_q        <= m_d;
         m_valid_q  <= m_valid_d;
         s_valid_q  <= s_valid_d;
         in_ready_q <= ~s_valid_d;
      end
   end

   // NOTE: skid payload has no reset; it is only ever read when s_valid_q is set.
   always_ff @(posedge clk) begin
      s_q <= s_d;
   end

   assign out_valid = m_valid_q;
   assign wrf_mem   = m_valid_q & m_q.wrf;
   assign wdc_mem   = m_valid_q & m_q.wdc;
   assign wdmem_mem = m_valid_q & m_q.wdmem;
   assign alud_mem  = m_q.alud;
   assign rd2_mem   = m_q.rd2;
   assign wa_mem    = m_q.wa;

`ifdef EXEMEM_FWD_EN
   // Only M is a forwarding source; r0 never matches.
   logic fwd_match;
   assign fwd_match = out_valid & wrf_mem & (wa_mem != '0) & (wa_mem == fwd_ra);
   assign fwd_hit   = fwd_match & ~wdc_mem;
   assign fwd_load  = fwd_match & wdc_mem;
   assign fwd_data  = alud_mem;
`endif

endmodule

// File: tb/tb_exe_mem_pipe_stage.sv
// Self-checking bench for exe_mem_pipe_stage: queue scoreboard of accepted instructions,
// compared in order as the MEM side consumes them. Define EXEMEM_FWD_EN to cover forwarding.
module tb_exe_mem_pipe_stage;
   localparam int DW = 32;
   localparam int AW = 5;

   typedef struct packed {
      logic          wrf;
      logic          wdc;
      logic          wdmem;
      logic [DW-1:0] alud;
      logic [DW-1:0] rd2;
      logic [AW-1:0] wa;
   } entry_t;

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, in_ready;
   logic          wrf_exe, wdc_exe, wdmem_exe;
   logic [DW-1:0] alud_exe, rd2_exe;
   logic [AW-1:0] wa_exe;
   logic          out_valid, out_ready;
   logic          wrf_mem, wdc_mem, wdmem_mem;
   logic [DW-1:0] alud_mem, rd2_mem;
   logic [AW-1:0] wa_mem;
`ifdef EXEMEM_FWD_EN
   logic [AW-1:0] fwd_ra;
   logic          fwd_hit, fwd_load;
   logic [DW-1:0] fwd_data;
`endif

   exe_mem_pipe_stage #(.DW(DW), .AW(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .wrf_exe   (wrf_exe),
      .wdc_exe   (wdc_exe),
      .wdmem_exe (wdmem_exe),
      .alud_exe  (alud_exe),
      .rd2_exe   (rd2_exe),
      .wa_exe    (wa_exe),
`ifdef EXEMEM_FWD_EN
      .fwd_ra    (fwd_ra),
      .fwd_hit   (fwd_hit),
      .fwd_load  (fwd_load),
      .fwd_data  (fwd_data),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .wrf_mem   (wrf_mem),
      .wdc_mem   (wdc_mem),
      .wdmem_mem (wdmem_mem),
      .alud_mem  (alud_mem),
      .rd2_mem   (rd2_mem),
      .wa_mem    (wa_mem)
   );

   always #5 clk = ~clk;

   int     checks = 0;
   int     errors = 0;
   entry_t sb[$];
   logic   mdl_ready;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic wrf, input logic wdc, input logic wdmem,
                        input logic [DW-1:0] alud, input logic [AW-1:0] wa);
      in_valid  = v;
      wrf_exe   = wrf;
      wdc_exe   = wdc;
      wdmem_exe = wdmem;
      alud_exe  = alud;
      rd2_exe   = alud ^ 32'hA5A5_0F0F;
      wa_exe    = wa;
   endtask

   // Compare current outputs with the model, then advance the model across the next edge.
   task automatic tick();
      entry_t e;
      logic   fo, fi;
      #1;
      check("in_ready", in_ready, mdl_ready);
      check("out_valid", out_valid, sb.size() != 0);
      if (sb.size() != 0) begin
         e = sb[0];
         check("ctrl_mem", {wrf_mem, wdc_mem, wdmem_mem}, {e.wrf, e.wdc, e.wdmem});
         check("alud_mem", alud_mem, e.alud);
         check("rd2_mem", rd2_mem, e.rd2);
         check("wa_mem", wa_mem, e.wa);
      end else begin
         check("ctrl_gated", {wrf_mem, wdc_mem, wdmem_mem}, 3'b000);
      end
`ifdef EXEMEM_FWD_EN
      if (sb.size() != 0) begin
         logic match;
         e     = sb[0];
         match = e.wrf && (e.wa != '0) && (e.wa == fwd_ra);
         check("fwd_hit", fwd_hit, match && !e.wdc);
         check("fwd_load", fwd_load, match && e.wdc);
         check("fwd_data", fwd_data, e.alud);
      end else begin
         check("fwd_idle", {fwd_hit, fwd_load}, 2'b00);
      end
`endif
      if (rst) begin
         sb.delete();
         mdl_ready = 1'b0;
      end else if (flush) begin
         sb.delete();
         mdl_ready = 1'b1;
      end else begin
         fo = (sb.size() != 0) && out_ready;
         fi = in_valid && mdl_ready;
         if (fo) void'(sb.pop_front());
         if (fi) sb.push_back('{wrf: wrf_exe, wdc: wdc_exe, wdmem: wdmem_exe,
                                alud: alud_exe, rd2: rd2_exe, wa: wa_exe});
         mdl_ready = sb.size() < 2;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
`ifdef EXEMEM_FWD_EN
      fwd_ra = '0;
`endif
      // 1. reset
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_ctrl", {wrf_mem, wdc_mem, wdmem_mem}, 3'b000);
      check("rst_alud", alud_mem, '0);
      check("rst_rd2", rd2_mem, '0);
      check("rst_wa", wa_mem, '0);
      sb.delete();
      mdl_ready = 1'b0;
      rst = 1'b0;
      tick();
      tick();

      // 2. full-rate stream
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 1'b1, i[0], i[1], i, i[AW-1:0]);
         tick();
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      repeat (2) tick();

      // 3. stall: A in M, B in S, C held upstream, then drain in order
      out_ready = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hA, 5'd10); tick();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hB, 5'd11); tick();
      drive(1'b1, 1'b0, 1'b1, 1'b1, 32'hC, 5'd12); tick();
      tick();
      out_ready = 1'b1;
      repeat (2) tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      repeat (2) tick();

      // 4. flush with both entries full and a same-cycle input
      out_ready = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h1A, 5'd3); tick();
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h1B, 5'd4); tick();
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h1C, 5'd5);
      flush = 1'b1; tick();
      flush = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      out_ready = 1'b1;
      repeat (2) tick();

      // 5. bubble after a writing instruction; data holds, control drops
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hDEAD, 5'd7); tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0); tick();
      check("bubble_ctrl", {wrf_mem, wdmem_mem}, 2'b00);
      check("bubble_alud_hold", alud_mem, 32'hDEAD);
      check("bubble_wa_hold", wa_mem, 5'd7);

`ifdef EXEMEM_FWD_EN
      // 6. forwarding from M
      out_ready = 1'b0;
      fwd_ra = 5'd5;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h1234, 5'd5); tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      #1;
      check("fwd6_hit", fwd_hit, 1'b1);
      check("fwd6_data", fwd_data, 32'h1234);
      out_ready = 1'b1; tick();
      fwd_ra = 5'd0;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h55, 5'd0); tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      #1;
      check("fwd6_r0_hit", fwd_hit, 1'b0);
      tick();
      fwd_ra = 5'd5;
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h77, 5'd5); tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      #1;
      check("fwd6_load", fwd_load, 1'b1);
      check("fwd6_load_hit", fwd_hit, 1'b0);
      tick();
`endif

      // Random traffic with occasional stalls and flushes.
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 1'($urandom),
               $urandom, AW'($urandom_range(0, 7)));
         out_ready = $urandom_range(0, 2) != 0;
         flush     = $urandom_range(0, 40) == 0;
`ifdef EXEMEM_FWD_EN
         fwd_ra    = AW'($urandom_range(0, 7));
`endif
         tick();
      end
      flush = 1'b0;
      out_ready = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
